// File: rtl/note_pkg.sv
// Shared note codes, tone divisors and the melody ROM for the note sequencer.
package note_pkg;

    typedef enum logic [2:0] {
        NOTE_REST = 3'd0,
        NOTE_DO   = 3'd1,
        NOTE_RE   = 3'd2,
        NOTE_MI   = 3'd3,
        NOTE_FA   = 3'd4,
        NOTE_SOL  = 3'd5,
        NOTE_LA   = 3'd6,
        NOTE_SI   = 3'd7
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [27:0] DIV_DO  = 28'd382219;
    localparam logic [27:0] DIV_RE  = 28'd340136;
    localparam logic [27:0] DIV_MI  = 28'd303030;
    localparam logic [27:0] DIV_FA  = 28'd286368;
    localparam logic [27:0] DIV_SOL = 28'd255102;
    localparam logic [27:0] DIV_LA  = 28'd227272;
    localparam logic [27:0] DIV_SI  = 28'd202429;

    // Entry = {note, beats}; beats code b plays for b+1 beats.
    localparam logic [4:0] MELODY_ROM [16] = '{
        {NOTE_RE,   2'd0}, {NOTE_MI,  2'd1}, {NOTE_REST, 2'd3}, {NOTE_SOL, 2'd0},
        {NOTE_LA,   2'd1}, {NOTE_SOL, 2'd0}, {NOTE_MI,   2'd0}, {NOTE_DO,  2'd3},
        {NOTE_FA,   2'd0}, {NOTE_FA,  2'd0}, {NOTE_MI,   2'd1}, {NOTE_RE,  2'd1},
        {NOTE_SI,   2'd0}, {NOTE_LA,  2'd0}, {NOTE_SOL,  2'd1}, {NOTE_DO,  2'd3}
    };

    function automatic logic [27:0] note_divisor(input logic [2:0] note);
        logic [27:0] div;
        case (note)
            NOTE_DO:  div = DIV_DO;
            NOTE_RE:  div = DIV_RE;
            NOTE_MI:  div = DIV_MI;
            NOTE_FA:  div = DIV_FA;
            NOTE_SOL: div = DIV_SOL;
            NOTE_LA:  div = DIV_LA;
            NOTE_SI:  div = DIV_SI;
            default:  div = 28'd0;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counts 0..divisor-1 and drives a registered 50% duty tone.
module tone_gen (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [27:0] divisor,
    output logic        clock_out
);

    logic [27:0] count;
    logic [27:0] half;

    assign half = divisor >> 1;

    always_ff @(posedge clock_in) begin
        if (reset || clear) begin
            count     <= 28'd0;
            clock_out <= 1'b0;
        end else if (enable) begin
            clock_out <= (count < half);
            count     <= (count == divisor - 28'd1) ? 28'd0 : count + 28'd1;
        end else begin
            count     <= 28'd0;
            clock_out <= 1'b0;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Melody player: steps through the ROM, playing each note then a silent gap.
// Define NOTE_SEQ_LOOP_EN to repeat the melody until stop or reset.
module note_sequencer
    import note_pkg::*;
#(
    parameter logic [27:0] NOTE_TICKS = 28'd12500000,
    parameter logic [27:0] GAP_TICKS  = 28'd1250000,
    parameter int          SONG_LEN   = 8,
    parameter int          DIV_SHIFT  = 0
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic       clock_out,
    output logic       busy,
    output logic [3:0] note_idx,
    output logic       done
);

    state_t      state, state_next;
    logic [27:0] dur_cnt;
    logic        dur_clear;
    logic [3:0]  idx_next;
    logic        done_next;
    logic [4:0]  entry;
    logic [2:0]  note;
    logic [1:0]  beats;
    logic [27:0] play_last;
    logic [27:0] divisor;
    logic        last_entry;
    logic        tone_clear;
    logic        tone_enable;

    assign entry      = MELODY_ROM[note_idx];
    assign note       = entry[4:2];
    assign beats      = entry[1:0];
    assign play_last  = NOTE_TICKS * (28'(beats) + 28'd1) - 28'd1;
    assign divisor    = note_divisor(note) >> DIV_SHIFT;
    assign last_entry = (note_idx == 4'(SONG_LEN - 1));

    always_comb begin
        state_next = state;
        idx_next   = note_idx;
        done_next  = 1'b0;
        if (stop) begin
            state_next = ST_IDLE;
            idx_next   = 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_PLAY;
                        idx_next   = 4'd0;
                    end
                end
                ST_PLAY: begin
                    if (dur_cnt == play_last) state_next = ST_GAP;
                end
                ST_GAP: begin
                    if (dur_cnt == GAP_TICKS - 28'd1) begin
                        if (last_entry) begin
                            done_next = 1'b1;
                            idx_next  = 4'd0;
`ifdef NOTE_SEQ_LOOP_EN
                            state_next = ST_PLAY;
`else
                            state_next = ST_IDLE;
`endif
                        end else begin
                            state_next = ST_PLAY;
                            idx_next   = note_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    idx_next   = 4'd0;
                end
            endcase
        end
    end

    // Every state change (including GAP->PLAY of the next note) restarts the timer.
    assign dur_clear   = (state_next != state) || (state == ST_IDLE);
    assign tone_clear  = !((state == ST_PLAY) && (state_next == ST_PLAY));
    assign tone_enable = (note != NOTE_REST);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state    <= ST_IDLE;
            dur_cnt  <= 28'd0;
            note_idx <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            dur_cnt  <= dur_clear ? 28'd0 : dur_cnt + 28'd1;
            note_idx <= idx_next;
            busy     <= (state_next != ST_IDLE);
            done     <= done_next;
        end
    end

    tone_gen u_tone_gen (
        .clock_in  (clock_in),
        .reset     (reset),
        .clear     (tone_clear),
        .enable    (tone_enable),
        .divisor   (divisor),
        .clock_out (clock_out)
    );

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: tone period, sequencing, rest, stop, reset, loop.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_tone, stop_tone, start_seq, stop_seq, start_loop, stop_loop;
    logic       tone_out_tone, tone_out_seq, tone_out_loop;
    logic       busy_tone, busy_seq, busy_loop;
    logic       done_tone, done_seq, done_loop;
    logic [3:0] idx_tone, idx_seq, idx_loop;

    int n_checks = 0;
    int n_errors = 0;
    int hi, lo, busy_cnt, first1, first2, hi0, hi2, done_cnt, done_at, prev;
    int seq_vals[$];

    always #5 clk = ~clk;

    note_sequencer #(.NOTE_TICKS(28'd4000), .GAP_TICKS(28'd4), .SONG_LEN(3), .DIV_SHIFT(8)) u_tone (
        .clock_in(clk), .reset(reset), .start(start_tone), .stop(stop_tone),
        .clock_out(tone_out_tone), .busy(busy_tone), .note_idx(idx_tone), .done(done_tone));

    note_sequencer #(.NOTE_TICKS(28'd20), .GAP_TICKS(28'd4), .SONG_LEN(3), .DIV_SHIFT(8)) u_seq (
        .clock_in(clk), .reset(reset), .start(start_seq), .stop(stop_seq),
        .clock_out(tone_out_seq), .busy(busy_seq), .note_idx(idx_seq), .done(done_seq));

    note_sequencer #(.NOTE_TICKS(28'd20), .GAP_TICKS(28'd4), .SONG_LEN(2), .DIV_SHIFT(8)) u_loop (
        .clock_in(clk), .reset(reset), .start(start_loop), .stop(stop_loop),
        .clock_out(tone_out_loop), .busy(busy_loop), .note_idx(idx_loop), .done(done_loop));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_tone = 1'b0; stop_tone = 1'b0;
        start_seq  = 1'b0; stop_seq  = 1'b0;
        start_loop = 1'b0; stop_loop = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy_seq, 0);
        check("rst_done", done_seq, 0);
        check("rst_idx", idx_seq, 0);
        check("rst_tone", tone_out_seq, 0);
        reset = 1'b0;
        tick();

        // start and stop together: stop wins
        start_seq = 1'b1; stop_seq = 1'b1;
        tick();
        start_seq = 1'b0; stop_seq = 1'b0;
        check("ss_busy", busy_seq, 0);
        check("ss_idx", idx_seq, 0);
        tick(); tick();
        check("ss_busy_later", busy_seq, 0);

        // tone period on RE with DIV_SHIFT=8: D=1328
        start_tone = 1'b1;
        tick();
        start_tone = 1'b0;
        check("tone_entry_busy", busy_tone, 1);
        check("tone_entry_low", tone_out_tone, 0);
        tick();
        check("tone_first_high", tone_out_tone, 1);
        hi = 0;
        while (tone_out_tone === 1'b1 && hi < 5000) begin hi++; tick(); end
        lo = 0;
        while (tone_out_tone === 1'b0 && lo < 5000) begin lo++; tick(); end
        check("tone_high_len", hi, 664);
        check("tone_low_len", lo, 664);
        check("tone_period", hi + lo, 1328);
        stop_tone = 1'b1;
        tick();
        stop_tone = 1'b0;
        check("tone_stop_busy", busy_tone, 0);
        check("tone_stop_out", tone_out_tone, 0);

        // full melody: beats {0,1,3}, entry 2 is a rest
        start_seq = 1'b1;
        tick();
        start_seq = 1'b0;
        busy_cnt = 0; first1 = -1; first2 = -1; hi0 = 0; hi2 = 0; done_cnt = 0; done_at = -1;
        for (int s = 0; s < 200; s++) begin
            if (busy_seq) busy_cnt++;
            if (idx_seq == 4'd1 && first1 < 0) first1 = s;
            if (idx_seq == 4'd2 && first2 < 0) first2 = s;
            if (busy_seq && idx_seq == 4'd0 && tone_out_seq) hi0++;
            if (busy_seq && idx_seq == 4'd2 && tone_out_seq) hi2++;
            if (done_seq) begin
                done_cnt++;
                if (done_at < 0) done_at = s;
            end
            if (s == 31) check("start_while_busy_idx", idx_seq, 1);
            start_seq = (s == 30);
            tick();
        end
        start_seq = 1'b0;
        check("seq_busy_cycles", busy_cnt, 152);
        check("seq_idx1_at", first1, 24);
        check("seq_idx2_at", first2, 68);
        check("seq_note0_high", hi0, 19);
        check("seq_rest_high", hi2, 0);
        check("seq_done_count", done_cnt, 1);
        check("seq_done_at", done_at, 152);

        // stop mid note 1 while the tone is high
        start_seq = 1'b1;
        tick();
        start_seq = 1'b0;
        repeat (30) tick();
        check("pre_stop_idx", idx_seq, 1);
        check("pre_stop_tone", tone_out_seq, 1);
        stop_seq = 1'b1;
        tick();
        stop_seq = 1'b0;
        check("stop_busy", busy_seq, 0);
        check("stop_tone", tone_out_seq, 0);
        check("stop_idx", idx_seq, 0);
        check("stop_done", done_seq, 0);
        done_cnt = 0;
        for (int s = 0; s < 10; s++) begin
            if (done_seq) done_cnt++;
            tick();
        end
        check("stop_no_done", done_cnt, 0);

        // reset mid note overrides start
        start_seq = 1'b1;
        tick();
        start_seq = 1'b0;
        repeat (30) tick();
        check("pre_reset_tone", tone_out_seq, 1);
        reset = 1'b1; start_seq = 1'b1;
        tick();
        check("reset_tone", tone_out_seq, 0);
        check("reset_busy", busy_seq, 0);
        check("reset_idx", idx_seq, 0);
        reset = 1'b0; start_seq = 1'b0;
        tick();

        // SONG_LEN=2: loops when NOTE_SEQ_LOOP_EN is defined, else plays once
        start_loop = 1'b1;
        tick();
        start_loop = 1'b0;
        busy_cnt = 0; done_cnt = 0; prev = -1;
        for (int s = 0; s < 200; s++) begin
            if (busy_loop) busy_cnt++;
            if (busy_loop && int'(idx_loop) != prev) begin
                seq_vals.push_back(int'(idx_loop));
                prev = int'(idx_loop);
            end
            if (done_loop) done_cnt++;
            tick();
        end
`ifdef NOTE_SEQ_LOOP_EN
        check("loop_busy_cycles", busy_cnt, 200);
        check("loop_done_count", done_cnt, 2);
        check("loop_seq_len", int'(seq_vals.size() >= 4), 1);
        check("loop_seq0", seq_vals.size() > 0 ? seq_vals[0] : -1, 0);
        check("loop_seq1", seq_vals.size() > 1 ? seq_vals[1] : -1, 1);
        check("loop_seq2", seq_vals.size() > 2 ? seq_vals[2] : -1, 0);
        check("loop_seq3", seq_vals.size() > 3 ? seq_vals[3] : -1, 1);
`else
        check("once_busy_cycles", busy_cnt, 68);
        check("once_done_count", done_cnt, 1);
        check("once_seq_len", seq_vals.size(), 2);
        check("once_seq0", seq_vals.size() > 0 ? seq_vals[0] : -1, 0);
        check("once_seq1", seq_vals.size() > 1 ? seq_vals[1] : -1, 1);
`endif
        stop_loop = 1'b1;
        tick();
        stop_loop = 1'b0;
        check("loop_stop_busy", busy_loop, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have the parameter NOTE_TICKS, default 28'd12500000, meaning clock cycles per beat (250 ms at 50 MHz).
REQ-002 The block SHALL have the parameter GAP_TICKS, default 28'd1250000, meaning silent cycles inserted after every note.
REQ-003 The block SHALL have the parameter SONG_LEN, default 8, meaning the number of melody ROM entries played (1..16).
REQ-004 The block SHALL have the parameter DIV_SHIFT, default 0, meaning the right-shift applied to every note divisor (a bench speed-up).
REQ-005 The block SHALL have the port clock_in, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have the port start, input, 1 bit: a one-cycle request to begin the melody.
REQ-008 The block SHALL have the port stop, input, 1 bit: aborts playback.
REQ-009 The block SHALL have the port clock_out, output reg, 1 bit: the square-wave tone driving the speaker.
REQ-010 The block SHALL have the port busy, output reg, 1 bit: high while in PLAY or GAP.
REQ-011 The block SHALL have the port note_idx, output reg, 4 bits: the index of the current ROM entry.
REQ-012 The block SHALL have the port done, output reg, 1 bit: a one-cycle pulse at the end of the melody.

Function
REQ-013 The FSM SHALL have the states IDLE, PLAY and GAP; the state after reset SHALL be IDLE.
REQ-014 Each ROM entry SHALL be {note[2:0], beats[1:0]}: note 0=rest, 1..7=do,re,mi,fa,sol,la,si; beats encoding b means b+1 beats.
REQ-015 IDLE with start=1 SHALL cause the next cycle to be PLAY, with note_idx=0, busy=1 and the tone counter=0.
REQ-016 PLAY SHALL last exactly (beats+1)*NOTE_TICKS cycles and then enter GAP.
REQ-017 GAP SHALL last exactly GAP_TICKS cycles with clock_out=0, then enter PLAY for note_idx+1 with the tone counter cleared.
REQ-018 At the end of GAP for note_idx=SONG_LEN-1, the block SHALL go to IDLE, pulse done=1 for one cycle and set busy=0.
REQ-019 The tone counter SHALL be 28 bits wide, with D = divisor>>DIV_SHIFT, and SHALL count 0..D-1 and wrap.
REQ-020 In PLAY, clock_out SHALL be registered as 1 when counter < D/2 and 0 otherwise; the period is exactly D cycles.
REQ-021 A rest (note 0) SHALL hold clock_out=0 for the whole PLAY duration, while timing stays identical.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 stop=1 in any state SHALL force IDLE on the next cycle, with clock_out=0, busy=0, note_idx=0 and no done pulse.
REQ-024 When start and stop are high in the same cycle, stop SHALL win.
REQ-025 The duration counter SHALL be cleared on every state entry and SHALL never wrap inside a state.

Reset
REQ-026 reset SHALL set state=IDLE, clock_out=0, busy=0, done=0, note_idx=0 and both counters to 0.
REQ-027 reset asserted mid-note SHALL silence the output on the next edge, and reset SHALL override start and stop.

Configuration
REQ-028 When NOTE_SEQ_LOOP_EN is defined, the block SHALL go from the end of GAP for the last entry to PLAY with note_idx=0, still pulsing done once per pass and keeping busy=1; playback SHALL end only on stop or reset.
REQ-029 When NOTE_SEQ_LOOP_EN is undefined, the block SHALL play the melody once per start, as specified in REQ-018.

Structure
REQ-030 The package note_pkg SHALL hold the 3-bit note codes, the divisor constants (DO 382219, RE 340136, MI 303030, FA 286368, SOL 255102, LA 227272, SI 202429) and the 16-entry melody ROM constant.
REQ-031 The tone generation SHALL be one sub-module, tone_gen (ports: clock_in, reset, clear, enable, divisor[27:0], clock_out), instantiated once.

Verification
REQ-032 The bench SHALL cover: with DIV_SHIFT=8, NOTE_TICKS=4000 and entry 0 = re, 1 beat, a start pulse -> clock_out period 1328 cycles, 664 high / 664 low, first high one cycle after entering PLAY.
REQ-033 The bench SHALL cover: with NOTE_TICKS=20, GAP_TICKS=4, SONG_LEN=3 and beats {0,1,3} -> busy high for exactly 20+40+80+3*4=152 cycles, then a done pulse of 1 cycle.
REQ-034 The bench SHALL cover: a rest entry -> clock_out=0 for the whole note while note_idx still advances on schedule.
REQ-035 The bench SHALL cover: stop in the middle of note 2 -> on the next cycle state=IDLE, clock_out=0, note_idx=0, no done pulse.
REQ-036 The bench SHALL cover: start and stop in the same cycle -> the block stays IDLE; a start while busy -> no restart (note_idx unchanged).
REQ-037 The bench SHALL cover: with NOTE_SEQ_LOOP_EN defined and SONG_LEN=2 -> note_idx sequence 0,1,0,1, a done pulse per pass and busy held high.
